free_reg_list: RTL and testbench

FREE_REG_LIST -- requirements
Module: free_reg_list

---
 rtl/reg_pkg.sv | 13 +
 rtl/uop_pkg.sv | 7 +
 rtl/frl_compact.sv | 45 ++++
 rtl/free_reg_list.sv | 177 +++++++++++++++++
 tb/tb_free_reg_list.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_pkg.sv
// Register-file sizing shared by rename, the retirement RAT and the free list.
// Provides the physical/architectural register counts, the PW/CW widths and
// preg_t, the physical register index type.
package reg_pkg;

    localparam int unsigned NUM_PHYS_REGS = 64;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned PW            = $clog2(NUM_PHYS_REGS);
    localparam int unsigned CW            = $clog2(NUM_PHYS_REGS + 1);

    typedef logic [PW-1:0] preg_t;

endpackage

// File: rtl/uop_pkg.sv
// Micro-op pipeline shared sizing.
// Provides INSTR_Q_WIDTH, the number of instructions renamed per cycle.
package uop_pkg;

    localparam int unsigned INSTR_Q_WIDTH = 4;

endpackage

// File: rtl/frl_compact.sv
// Free-port compaction for the free list: a running count of eligible ports
// gives each port its write offset from tail; ports beyond the available
// space are refused and flagged.
// Ports:
//   i_valid     - per-port eligible free
//   i_space     - slots left on the list after this cycle's allocation
//   o_offset_c  - per-port offset from tail (valid where accepted)
//   o_accept_c  - per-port accepted mask
//   o_num_acc_c - number of accepted frees
//   o_drop_c    - an eligible free was refused for lack of space
module frl_compact #(
    parameter  int unsigned FREE_WIDTH = 10,
    parameter  int unsigned CNT_W      = 7,
    localparam int unsigned OFF_W      = $clog2(FREE_WIDTH + 1)
) (
    input  logic [FREE_WIDTH-1:0]            i_valid,
    input  logic [CNT_W-1:0]                 i_space,
    output logic [FREE_WIDTH-1:0][OFF_W-1:0] o_offset_c,
    output logic [FREE_WIDTH-1:0]            o_accept_c,
    output logic [OFF_W-1:0]                 o_num_acc_c,
    output logic                             o_drop_c
);

    // Lowest-indexed ports win the remaining space.
    always_comb begin : p_compact
        int unsigned n;
        n           = 0;
        o_offset_c  = '0;
        o_accept_c  = '0;
        o_drop_c    = 1'b0;
        for (int unsigned i = 0; i < FREE_WIDTH; i++) begin
            o_offset_c[i] = OFF_W'(n);
            if (i_valid[i]) begin
                if (n < 32'(i_space)) begin
                    o_accept_c[i] = 1'b1;
                    n = n + 1;
                end else begin
                    o_drop_c = 1'b1;
                end
            end
        end
        o_num_acc_c = OFF_W'(n);
    end

endmodule

// File: rtl/free_reg_list.sv
// Physical register free list: circular buffer feeding rename allocations
// from head and absorbing retirement frees at tail.
// Optional macro FRL_DUP_CHECK_EN adds an on-list bitmap that drops and flags
// duplicate frees; without it dup_err is tied low.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   free_valid_in - per-port free request
//   free_reg_in   - register to free per port
//   alloc_req     - per-slot allocation request
//   alloc_grant   - all requested slots served (combinational)
//   alloc_reg     - allocated register per slot, 0 when unserved
//   free_count    - registers currently on the list
//   overflow_err  - sticky, a free was dropped for lack of space
//   dup_err       - sticky, a duplicate free was dropped
module free_reg_list
    import uop_pkg::*;
#(
    parameter  int unsigned NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
    parameter  int unsigned NUM_ARCH_REGS = reg_pkg::NUM_ARCH_REGS,
    parameter  int unsigned ALLOC_WIDTH   = INSTR_Q_WIDTH,
    parameter  int unsigned FREE_WIDTH    = 2 * INSTR_Q_WIDTH + 2,
    localparam int unsigned PREG_W        = $clog2(NUM_PHYS_REGS),
    localparam int unsigned CNT_W         = $clog2(NUM_PHYS_REGS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FREE_WIDTH-1:0]             free_valid_in,
    input  logic [FREE_WIDTH-1:0][PREG_W-1:0] free_reg_in,
    input  logic [ALLOC_WIDTH-1:0]            alloc_req,
    output logic                              alloc_grant,
    output logic [ALLOC_WIDTH-1:0][PREG_W-1:0] alloc_reg,
    output logic [CNT_W-1:0]                  free_count,
    output logic                              overflow_err,
    output logic                              dup_err
);

    localparam int unsigned INIT_CNT = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;
    localparam int unsigned OFF_W    = $clog2(FREE_WIDTH + 1);
    localparam int unsigned KW       = $clog2(ALLOC_WIDTH + 1);

    logic [PREG_W-1:0] r_mem [NUM_PHYS_REGS];
    logic [PREG_W-1:0] r_head;
    logic [PREG_W-1:0] r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    logic [KW-1:0]                       w_k;
    logic                                w_grant;
    logic [CNT_W-1:0]                    w_after_alloc;
    logic [CNT_W-1:0]                    w_space;
    logic [FREE_WIDTH-1:0]               w_elig;
    logic [FREE_WIDTH-1:0][OFF_W-1:0]    w_off;
    logic [FREE_WIDTH-1:0]               w_acc;
    logic [OFF_W-1:0]                    w_nacc;
    logic                                w_ovf_hit;

    function automatic logic [PREG_W-1:0] ptr_add(input logic [PREG_W-1:0] p,
                                                  input int unsigned n);
        return PREG_W'((32'(p) + n) % NUM_PHYS_REGS);
    endfunction

    // Number of requested slots this cycle.
    always_comb begin : p_popcnt
        w_k = '0;
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            w_k = w_k + KW'(alloc_req[i]);
        end
    end

    assign w_grant     = (32'(r_count) >= 32'(w_k));
    assign alloc_grant = w_grant;

    // j-th requested slot reads head+j; nothing is handed out on a refusal.
    always_comb begin : p_alloc
        int unsigned j;
        j         = 0;
        alloc_reg = '0;
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            if (w_grant && alloc_req[i]) begin
                alloc_reg[i] = r_mem[ptr_add(r_head, j)];
                j = j + 1;
            end
        end
    end

    assign w_after_alloc = r_count - (w_grant ? CNT_W'(w_k) : '0);
    assign w_space       = CNT_W'(NUM_PHYS_REGS) - w_after_alloc;

`ifdef FRL_DUP_CHECK_EN
    logic [NUM_PHYS_REGS-1:0] r_onlist;
    logic                     r_dup;
    logic                     w_dup_hit;

    // A free is a duplicate if already listed or named by a lower port.
    always_comb begin : p_dup
        logic seen;
        seen      = 1'b0;
        w_elig    = '0;
        w_dup_hit = 1'b0;
        for (int unsigned i = 0; i < FREE_WIDTH; i++) begin
            seen = r_onlist[free_reg_in[i]];
            for (int unsigned j = 0; j < i; j++) begin
                if (free_valid_in[j] && (free_reg_in[j] == free_reg_in[i])) begin
                    seen = 1'b1;
                end
            end
            if (free_valid_in[i]) begin
                if (seen) begin
                    w_dup_hit = 1'b1;
                end else begin
                    w_elig[i] = 1'b1;
                end
            end
        end
    end

    // On-list bitmap tracks the list contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
                r_onlist[i] <= (i > NUM_ARCH_REGS);
            end
            r_dup <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < ALLOC_WIDTH; s++) begin
                if (w_grant && alloc_req[s]) r_onlist[alloc_reg[s]] <= 1'b0;
            end
            for (int unsigned p = 0; p < FREE_WIDTH; p++) begin
                if (w_acc[p]) r_onlist[free_reg_in[p]] <= 1'b1;
            end
            if (w_dup_hit) r_dup <= 1'b1;
        end
    end

    assign dup_err = r_dup;
`else
    assign w_elig  = free_valid_in;
    assign dup_err = 1'b0;
`endif

    frl_compact #(
        .FREE_WIDTH (FREE_WIDTH),
        .CNT_W      (CNT_W)
    ) u_compact (
        .i_valid     (w_elig),
        .i_space     (w_space),
        .o_offset_c  (w_off),
        .o_accept_c  (w_acc),
        .o_num_acc_c (w_nacc),
        .o_drop_c    (w_ovf_hit)
    );

    // List storage, pointers and count; reset reloads the post-boot list.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
                r_mem[i] <= (i < INIT_CNT) ? PREG_W'(i + NUM_ARCH_REGS + 1) : '0;
            end
            r_head  <= '0;
            r_tail  <= PREG_W'(INIT_CNT);
            r_count <= CNT_W'(INIT_CNT);
            r_ovf   <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < FREE_WIDTH; p++) begin
                if (w_acc[p]) r_mem[ptr_add(r_tail, 32'(w_off[p]))] <= free_reg_in[p];
            end
            if (w_grant) r_head <= ptr_add(r_head, 32'(w_k));
            r_tail  <= ptr_add(r_tail, 32'(w_nacc));
            r_count <= w_after_alloc + CNT_W'(w_nacc);
            if (w_ovf_hit) r_ovf <= 1'b1;
        end
    end

    assign free_count   = r_count;
    assign overflow_err = r_ovf;

endmodule

// File: tb/tb_free_reg_list.sv
// Directed bench for free_reg_list with a queue-based reference list and a
// scoreboard of expected allocation results.
module tb_free_reg_list;
    import reg_pkg::*;

    localparam int unsigned NP   = 64;
    localparam int unsigned NA   = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned FW   = 10;
    localparam int unsigned CW_T = 7;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [FW-1:0]         free_valid_in;
    preg_t [FW-1:0]        free_reg_in;
    logic [AW-1:0]         alloc_req;
    logic                  alloc_grant;
    preg_t [AW-1:0]        alloc_reg;
    logic [CW_T-1:0]       free_count;
    logic                  overflow_err;
    logic                  dup_err;

    int checks;
    int failures;
    int model[$];
    int exp_q[$];
    bit m_ovf;
    bit m_dup;

    free_reg_list dut (
        .clk           (clk),
        .rst           (rst),
        .free_valid_in (free_valid_in),
        .free_reg_in   (free_reg_in),
        .alloc_req     (alloc_req),
        .alloc_grant   (alloc_grant),
        .alloc_reg     (alloc_reg),
        .free_count    (free_count),
        .overflow_err  (overflow_err),
        .dup_err       (dup_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model.delete();
        for (int v = NA + 1; v < NP; v++) model.push_back(v);
        m_ovf = 1'b0;
        m_dup = 1'b0;
    endtask

    // Reset with junk traffic in flight; the list must read back as fresh.
    task automatic do_reset();
        rst           = 1'b1;
        alloc_req     = '1;
        free_valid_in = '1;
        for (int p = 0; p < FW; p++) free_reg_in[p] = preg_t'(p);
        @(posedge clk); #1;
        model_reset();
        @(negedge clk);
        chk("rst_grant", 32'(alloc_grant), 1);
        for (int i = 0; i < AW; i++) chk($sformatf("rst_slot%0d", i), 32'(alloc_reg[i]), 32'(NA + 1 + i));
        @(posedge clk); #1;
        rst           = 1'b0;
        alloc_req     = '0;
        free_valid_in = '0;
        free_reg_in   = '0;
        chk("rst_count", 32'(free_count), 32'(NP - NA - 1));
        chk("rst_ovf", 32'(overflow_err), 0);
        chk("rst_dup", 32'(dup_err), 0);
    endtask

    // One cycle: drive, predict into the scoreboard, compare outputs.
    task automatic step(input logic [AW-1:0] req, input logic [FW-1:0] fv, input string tag);
        int  k;
        int  v;
        bit  grant;
        bit  drop;
        int  snap[$];
        alloc_req     = req;
        free_valid_in = fv;
        k     = $countones(req);
        grant = (model.size() >= k);
        snap  = model;
        exp_q.push_back(int'(grant));
        for (int i = 0; i < AW; i++) begin
            if (grant && req[i]) exp_q.push_back(model.pop_front());
            else                 exp_q.push_back(0);
        end
        for (int p = 0; p < FW; p++) begin
            if (fv[p]) begin
                v    = int'(free_reg_in[p]);
                drop = 1'b0;
`ifdef FRL_DUP_CHECK_EN
                foreach (snap[s]) if (snap[s] == v) drop = 1'b1;
                for (int q = 0; q < p; q++) begin
                    if (fv[q] && int'(free_reg_in[q]) == v) drop = 1'b1;
                end
                if (drop) m_dup = 1'b1;
`endif
                if (!drop) begin
                    if (model.size() < NP) model.push_back(v);
                    else                   m_ovf = 1'b1;
                end
            end
        end
        @(negedge clk);
        chk({tag, "_grant"}, 32'(alloc_grant), exp_q.pop_front());
        for (int i = 0; i < AW; i++) chk($sformatf("%s_slot%0d", tag, i), 32'(alloc_reg[i]), exp_q.pop_front());
        @(posedge clk); #1;
        alloc_req     = '0;
        free_valid_in = '0;
        chk({tag, "_count"}, 32'(free_count), model.size());
        chk({tag, "_ovf"}, 32'(overflow_err), 32'(m_ovf));
        chk({tag, "_dup"}, 32'(dup_err), 32'(m_dup));
    endtask

    // Free a list of registers, up to FW per cycle, ports from 0.
    task automatic free_vals(input int vals[$], input string tag);
        logic [FW-1:0] m;
        while (vals.size() > 0) begin
            m = '0;
            for (int p = 0; p < FW && vals.size() > 0; p++) begin
                free_reg_in[p] = preg_t'(vals.pop_front());
                m[p] = 1'b1;
            end
            step('0, m, tag);
        end
    endtask

    // Allocate everything on the list, checking order against the model.
    task automatic drain_all(input string tag);
        logic [AW-1:0] m;
        while (model.size() > 0) begin
            m = '0;
            for (int i = 0; i < AW && i < model.size(); i++) m[i] = 1'b1;
            step(m, '0, tag);
        end
    endtask

    initial begin
        int vals[$];
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        alloc_req     = '0;
        free_valid_in = '0;
        free_reg_in   = '0;

        do_reset();
        step(4'b1111, '0, "a1111");

        do_reset();
        step(4'b1010, '0, "a1010");
        repeat (6) step(4'b1111, '0, "drain");
        step(4'b0111, '0, "drain3");
        free_reg_in    = '0;
        free_reg_in[0] = preg_t'(5);
        free_reg_in[3] = preg_t'(7);
        step(4'b0111, 10'b00_0000_1001, "refuse");
        step(4'b1111, '0, "reuse");

        // Wrap: empty the list, refill twice so tail crosses the end.
        do_reset();
        repeat (7) step(4'b1111, '0, "w_alloc");
        step(4'b0111, '0, "w_alloc3");
        vals.delete();
        for (int i = 0; i < 31; i++) vals.push_back((i * 7) % 31 + 1);
        free_vals(vals, "w_free0");
        drain_all("w_back0");
        vals.delete();
        for (int i = 0; i < 31; i++) vals.push_back((i * 11) % 31 + 33);
        free_vals(vals, "w_free1");
        free_reg_in[0] = preg_t'(9);
        free_reg_in[1] = preg_t'(10);
        step(4'b0011, 10'b11, "w_mixed");
        drain_all("w_back1");

        // Overflow at near-full list.
        do_reset();
        step(4'b1111, '0, "o_a");
        step(4'b1111, '0, "o_b");
        vals.delete();
        for (int i = 0; i < 39; i++) vals.push_back(i);
        free_vals(vals, "o_fill");
        free_reg_in[0] = preg_t'(39);
        free_reg_in[1] = preg_t'(40);
        free_reg_in[2] = preg_t'(1);
        free_reg_in[3] = preg_t'(2);
        step('0, 10'b1111, "o_over");
        step('0, '0, "o_hold");
        step(4'b0001, '0, "o_hold2");
        do_reset();

        // Duplicate frees: already listed, and repeated within one cycle.
        free_reg_in[0] = preg_t'(40);
        step('0, 10'b1, "dup40");
        free_reg_in[0] = preg_t'(1);
        free_reg_in[1] = preg_t'(1);
        step('0, 10'b11, "dup_same");
        drain_all("dup_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
